// File: rtl/xillybus_mem8_pkg.sv
// Shared sizes and arbiter state encoding for the mem_8 seekable store.
package xillybus_mem8_pkg;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    HOST  = 2'd0,
    DRAIN = 2'd1,
    LOCAL = 2'd2
  } state_e;

endpackage

// File: rtl/xillybus_mem8_arbiter_if.sv
// Host (Xillybus mem_8) and local-client signals; master drives requests, slave is the arbiter.
interface xillybus_mem8_arbiter_if;
  import xillybus_mem8_pkg::*;

  logic              user_w_mem_8_wren;
  logic              user_w_mem_8_open;
  logic [DATA_W-1:0] user_w_mem_8_data;
  logic              user_w_mem_8_full;
  logic              user_r_mem_8_rden;
  logic              user_r_mem_8_open;
  logic [DATA_W-1:0] user_r_mem_8_data;
  logic              user_r_mem_8_empty;
  logic              user_r_mem_8_eof;
  logic [ADDR_W-1:0] user_mem_8_addr;
  logic              user_mem_8_addr_update;
  logic              loc_req;
  logic              loc_we;
  logic [ADDR_W-1:0] loc_addr;
  logic [DATA_W-1:0] loc_wdata;
  logic              loc_gnt;
  logic [DATA_W-1:0] loc_rdata;
  logic              loc_rvalid;

  modport master (
    output user_w_mem_8_wren, user_w_mem_8_open, user_w_mem_8_data,
    output user_r_mem_8_rden, user_r_mem_8_open,
    output user_mem_8_addr, user_mem_8_addr_update,
    output loc_req, loc_we, loc_addr, loc_wdata,
    input  user_w_mem_8_full, user_r_mem_8_data, user_r_mem_8_empty, user_r_mem_8_eof,
    input  loc_gnt, loc_rdata, loc_rvalid
  );

  modport slave (
    input  user_w_mem_8_wren, user_w_mem_8_open, user_w_mem_8_data,
    input  user_r_mem_8_rden, user_r_mem_8_open,
    input  user_mem_8_addr, user_mem_8_addr_update,
    input  loc_req, loc_we, loc_addr, loc_wdata,
    output user_w_mem_8_full, user_r_mem_8_data, user_r_mem_8_empty, user_r_mem_8_eof,
    output loc_gnt, loc_rdata, loc_rvalid
  );

endinterface

// File: rtl/xillybus_mem8_ram.sv
// 32x8 store; the owning side (by arbiter state) gets the single write port, reads register in one cycle.
// Writes are blocked while reset is asserted so an aborted access never lands.
module xillybus_mem8_ram
  import xillybus_mem8_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  state_e            state_i,
  input  logic              h_we_i,
  input  logic              h_re_i,
  input  logic [ADDR_W-1:0] h_addr_i,
  input  logic [DATA_W-1:0] h_wdata_i,
  input  logic              l_we_i,
  input  logic              l_re_i,
  input  logic [ADDR_W-1:0] l_addr_i,
  input  logic [DATA_W-1:0] l_wdata_i,
  output logic [DATA_W-1:0] h_rdata_o,
  output logic [DATA_W-1:0] l_rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] h_rdata_q, l_rdata_q;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    we    = 1'b0;
    waddr = h_addr_i;
    wdata = h_wdata_i;
    case (state_i)
      HOST:  we = h_we_i;
      LOCAL: begin
        we    = l_we_i;
        waddr = l_addr_i;
        wdata = l_wdata_i;
      end
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i && we) mem_q[waddr] <= wdata;
  end

  // Reads sample the array before this cycle's write, so a same-cycle wren/rden returns the old byte.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      h_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      if (state_i == HOST && h_re_i)  h_rdata_q <= mem_q[h_addr_i];
      if (state_i == LOCAL && l_re_i) l_rdata_q <= mem_q[l_addr_i];
    end
  end

  assign h_rdata_o = h_rdata_q;
  assign l_rdata_o = l_rdata_q;

endmodule

// File: rtl/xillybus_mem8_arbiter.sv
// Shares the mem_8 store between the Xillybus host and one local client; host reads return one cycle after rden.
// A pending local request stalls the host via registered full/empty after a bounded host run, then a DRAIN cycle.
module xillybus_mem8_arbiter
  import xillybus_mem8_pkg::*;
#(
  parameter int MAX_HOST_RUN  = 16,
  parameter int MAX_LOCAL_RUN = 4
) (
  input  logic                   bus_clk,
  input  logic                   bus_reset_n,
  xillybus_mem8_arbiter_if.slave bus
);

  localparam logic [7:0] HostRunMax   = 8'(MAX_HOST_RUN);
  localparam logic [3:0] LocalRunLast = 4'(MAX_LOCAL_RUN - 1);

  state_e            state_q, state_d;
  logic [7:0]        run_q, run_d;
  logic [3:0]        lrun_q, lrun_d;
  logic [ADDR_W-1:0] hptr_q, hptr_d, hbase;
  logic              full_q, full_d, empty_q, empty_d;
  logic              rvalid_q, rvalid_d;
  logic              host_own, any_open, gnt;

  assign host_own = (state_q == HOST);
  assign any_open = bus.user_w_mem_8_open | bus.user_r_mem_8_open;
  assign hbase    = (host_own && bus.user_mem_8_addr_update) ? bus.user_mem_8_addr : hptr_q;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    lrun_d  = lrun_q;
    gnt     = 1'b0;
    case (state_q)
      HOST: begin
        if (bus.loc_req && run_q != HostRunMax) run_d = run_q + 8'd1;
        if (bus.loc_req && (run_q == HostRunMax || !any_open)) state_d = DRAIN;
      end
      DRAIN: begin
        lrun_d  = '0;
        state_d = LOCAL;
      end
      LOCAL: begin
        gnt = bus.loc_req;
        if (!bus.loc_req) begin
          state_d = HOST;
        end else begin
          lrun_d = lrun_q + 4'd1;
          if (lrun_q == LocalRunLast) state_d = HOST;
        end
      end
      default: state_d = HOST;
    endcase
    if (state_d == HOST && state_q != HOST) run_d = '0;
  end

  // The pointer only moves on host strobes while the host owns the array.
  always_comb begin
    hptr_d = hptr_q;
    if (host_own) begin
      hptr_d = (bus.user_w_mem_8_wren | bus.user_r_mem_8_rden) ? hbase + ADDR_W'(1) : hbase;
    end
  end

  assign full_d   = (state_d == HOST) ? ~bus.user_w_mem_8_open : 1'b1;
  assign empty_d  = (state_d == HOST) ? ~bus.user_r_mem_8_open : 1'b1;
  assign rvalid_d = gnt & ~bus.loc_we;

  always_ff @(posedge bus_clk) begin
    if (!bus_reset_n) begin
      state_q  <= HOST;
      run_q    <= '0;
      lrun_q   <= '0;
      hptr_q   <= '0;
      full_q   <= 1'b1;
      empty_q  <= 1'b1;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      lrun_q   <= lrun_d;
      hptr_q   <= hptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      rvalid_q <= rvalid_d;
    end
  end

  xillybus_mem8_ram u_ram (
    .clk_i     (bus_clk),
    .rst_n_i   (bus_reset_n),
    .state_i   (state_q),
    .h_we_i    (bus.user_w_mem_8_wren),
    .h_re_i    (bus.user_r_mem_8_rden),
    .h_addr_i  (hbase),
    .h_wdata_i (bus.user_w_mem_8_data),
    .l_we_i    (gnt & bus.loc_we),
    .l_re_i    (gnt & ~bus.loc_we),
    .l_addr_i  (bus.loc_addr),
    .l_wdata_i (bus.loc_wdata),
    .h_rdata_o (bus.user_r_mem_8_data),
    .l_rdata_o (bus.loc_rdata)
  );

  assign bus.user_w_mem_8_full  = full_q;
  assign bus.user_r_mem_8_empty = empty_q;
  assign bus.user_r_mem_8_eof   = 1'b0;
  assign bus.loc_gnt            = gnt;
  assign bus.loc_rvalid         = rvalid_q;

endmodule
